// File: rtl/scr1_vec_dmem_pkg.sv
// Shared types and helpers for the vector-wide data memory responder.
// Holds the SCR1 memory interface enums, the vector line type, the
// responder FSM state type, the byte-enable builder and the request
// legality check (range and natural alignment).
package scr1_vec_dmem_pkg;

  localparam int SCR1_DMEM_AWIDTH = 32;

  typedef logic [127:0] type_vector;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  localparam int VEC_W  = $bits(type_vector);
  localparam int VEC_NB = VEC_W / 8;
  localparam int LANE_W = $clog2(VEC_NB);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } type_vec_dmem_state_e;

  // Byte enables of one access inside a line, starting at byte lane 'lane'.
  function automatic logic [VEC_NB-1:0] f_byte_en(type_scr1_mem_width_e width,
                                                   logic [LANE_W-1:0]    lane);
    logic [VEC_NB-1:0] base;
    case (width)
      SCR1_MEM_WIDTH_BYTE:  base = VEC_NB'(4'h1);
      SCR1_MEM_WIDTH_HWORD: base = VEC_NB'(4'h3);
      SCR1_MEM_WIDTH_WORD:  base = VEC_NB'(4'hF);
      default:              base = '0;
    endcase
    return base << lane;
  endfunction

  // True when the access lies inside [base, base+span) and is naturally
  // aligned. The upper bound is compared one bit wider so it cannot wrap.
  function automatic logic f_req_ok(type_scr1_mem_width_e        width,
                                    logic [SCR1_DMEM_AWIDTH-1:0] addr,
                                    logic [SCR1_DMEM_AWIDTH-1:0] base,
                                    logic [SCR1_DMEM_AWIDTH:0]   span);
    logic [SCR1_DMEM_AWIDTH-1:0] off;
    logic                        in_range;
    logic                        aligned;
    off      = addr - base;
    in_range = (addr >= base) && ({1'b0, addr} < ({1'b0, base} + span));
    case (width)
      SCR1_MEM_WIDTH_BYTE:  aligned = 1'b1;
      SCR1_MEM_WIDTH_HWORD: aligned = ((off & 'h1) == '0);
      SCR1_MEM_WIDTH_WORD:  aligned = ((off & 'h3) == '0);
      default:              aligned = 1'b0;
    endcase
    return in_range & aligned;
  endfunction

endpackage

// File: rtl/scr1_vec_dmem_array.sv
// Line storage for the vector data memory: MEM_LINES lines of VEC_W bits.
// Ports:
//   clk      write clock
//   i_raddr  read line index; o_rdata follows it combinationally
//   o_rdata  addressed line
//   i_we     write strobe
//   i_waddr  write line index
//   i_be     per-byte write enables
//   i_wdata  write data, already placed at its byte lanes
// Contents are not reset.
module scr1_vec_dmem_array
  import scr1_vec_dmem_pkg::*;
#(
  parameter int MEM_LINES = 1024,
  parameter int LINE_W    = $clog2(MEM_LINES)
) (
  input  logic              clk,
  input  logic [LINE_W-1:0] i_raddr,
  output logic [VEC_W-1:0]  o_rdata,
  input  logic              i_we,
  input  logic [LINE_W-1:0] i_waddr,
  input  logic [VEC_NB-1:0] i_be,
  input  logic [VEC_W-1:0]  i_wdata
);

  logic [VEC_W-1:0] r_mem [MEM_LINES];

  assign o_rdata = r_mem[i_raddr];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < VEC_NB; b++) begin
        if (i_be[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/scr1_vec_dmem_responder.sv
// Responder end of the core data memory interface with vector-wide data.
// Each accepted request is answered RESP_LATENCY cycles later; reads return
// the whole line, writes commit with byte enables in the response cycle.
// Out-of-range, misaligned or width-ERROR requests answer RDY_ER and never
// touch the memory.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   dmem_req       request valid
//   dmem_req_ack   request accepted this cycle
//   dmem_cmd       read / write
//   dmem_width     byte / half-word / word (ERROR is rejected)
//   dmem_addr      byte address
//   dmem_wdata     write data, sub-line data in the low bits
//   dmem_rdata     full line, non-zero only in an RDY_OK read response
//   dmem_resp      NOTRDY / RDY_OK / RDY_ER
//
// state | meaning
// IDLE  | no request pending, accepting
// WAIT  | request captured, counting down to its response cycle
// RESP  | response on the bus, write commits, next request may be accepted
module scr1_vec_dmem_responder
  import scr1_vec_dmem_pkg::*;
#(
  parameter logic [SCR1_DMEM_AWIDTH-1:0] BASE_ADDR    = '0,
  parameter int                          MEM_LINES    = 1024,
  parameter int                          VEC_BYTES    = 16,
  parameter int                          RESP_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        dmem_req,
  output logic                        dmem_req_ack,
  input  type_scr1_mem_cmd_e          dmem_cmd,
  input  type_scr1_mem_width_e        dmem_width,
  input  logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr,
  input  type_vector                  dmem_wdata,
  output type_vector                  dmem_rdata,
  output type_scr1_mem_resp_e         dmem_resp
);

  localparam int LINE_W    = $clog2(MEM_LINES);
  localparam int LANE_BITS = $clog2(VEC_BYTES);
  localparam logic [SCR1_DMEM_AWIDTH:0] SPAN =
    (SCR1_DMEM_AWIDTH+1)'(MEM_LINES) * (SCR1_DMEM_AWIDTH+1)'(VEC_BYTES);
  localparam logic [2:0] LAT_M1 = 3'(RESP_LATENCY - 1);

  type_vec_dmem_state_e        r_state;
  type_vec_dmem_state_e        w_next_state;
  logic [2:0]                  r_cnt;
  logic [2:0]                  w_cnt_next;
  logic                        r_wr;
  logic                        r_err;
  logic [LINE_W-1:0]           r_line;
  logic [VEC_NB-1:0]           r_be;
  type_vector                  r_wdata;

  logic [SCR1_DMEM_AWIDTH-1:0] w_off;
  logic [LANE_W-1:0]           w_lane;
  logic [LINE_W-1:0]           w_line;
  logic                        w_hs;
  logic                        w_we;
  type_vector                  w_rd_line;

  assign w_off  = dmem_addr - BASE_ADDR;
  assign w_lane = LANE_W'(w_off);
  assign w_line = LINE_W'(w_off >> LANE_BITS);

  // Gated by rst so the ack is low for the whole reset window, not just
  // after the state register has been cleared.
  assign dmem_req_ack = ~rst & ((r_state == IDLE) | (r_state == RESP));
  assign w_hs         = dmem_req & dmem_req_ack;

  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_we         = 1'b0;
    dmem_resp    = SCR1_MEM_RESP_NOTRDY;
    dmem_rdata   = '0;
    case (r_state)
      IDLE: begin
        if (w_hs) begin
          w_next_state = (RESP_LATENCY == 1) ? RESP : WAIT;
          w_cnt_next   = LAT_M1;
        end
      end
      WAIT: begin
        w_cnt_next = r_cnt - 3'd1;
        if (r_cnt == 3'd1) w_next_state = RESP;
      end
      RESP: begin
        dmem_resp  = r_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
        dmem_rdata = (!r_wr && !r_err) ? w_rd_line : '0;
        w_we       = r_wr & ~r_err;
        if (w_hs) begin
          w_next_state = (RESP_LATENCY == 1) ? RESP : WAIT;
          w_cnt_next   = LAT_M1;
        end else begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
      r_line  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
      if (w_hs) begin
        r_wr    <= (dmem_cmd == SCR1_MEM_CMD_WR);
        r_err   <= ~f_req_ok(dmem_width, dmem_addr, BASE_ADDR, SPAN);
        r_line  <= w_line;
        r_be    <= f_byte_en(dmem_width, w_lane);
        // Move the sub-line data up to its lane; the byte enables drop
        // whatever lands outside the access.
        r_wdata <= dmem_wdata << {w_lane, 3'b000};
      end
    end
  end

  scr1_vec_dmem_array #(
    .MEM_LINES (MEM_LINES),
    .LINE_W    (LINE_W)
  ) u_array (
    .clk     (clk),
    .i_raddr (r_line),
    .o_rdata (w_rd_line),
    .i_we    (w_we),
    .i_waddr (r_line),
    .i_be    (r_be),
    .i_wdata (r_wdata)
  );

endmodule

// File: tb/tb_scr1_vec_dmem_responder.sv
module tb_scr1_vec_dmem_responder;
  import scr1_vec_dmem_pkg::*;

  localparam int NI = 3;
  localparam int LAT [NI] = '{1, 3, 4};
  localparam int MEMB = 1024 * 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic                 req   [NI];
  logic                 ack   [NI];
  type_scr1_mem_cmd_e   cmd   [NI];
  type_scr1_mem_width_e width [NI];
  logic [31:0]          addr  [NI];
  type_vector           wdata [NI];
  type_vector           rdata [NI];
  type_scr1_mem_resp_e  resp  [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    scr1_vec_dmem_responder #(
      .BASE_ADDR    (32'h0),
      .MEM_LINES    (1024),
      .VEC_BYTES    (16),
      .RESP_LATENCY (LAT[g])
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .dmem_req     (req[g]),
      .dmem_req_ack (ack[g]),
      .dmem_cmd     (cmd[g]),
      .dmem_width   (width[g]),
      .dmem_addr    (addr[g]),
      .dmem_wdata   (wdata[g]),
      .dmem_rdata   (rdata[g]),
      .dmem_resp    (resp[g])
    );
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Memory as a byte map (only bytes the bench has written are known),
  // plus one outstanding request per instance with its due cycle.
  logic [7:0]  mm [int];
  logic        p_v   [NI];
  int          p_cyc [NI];
  logic        p_wr  [NI];
  logic        p_err [NI];
  logic [31:0] p_addr[NI];
  int          p_nb  [NI];
  logic [31:0] p_wd  [NI];

  typedef struct {
    int                  inst;
    int                  cyc;
    type_scr1_mem_resp_e resp;
    type_vector          data;
  } log_t;
  log_t lg[$];

  function automatic int key(int i, logic [31:0] a);
    return i * (1 << 20) + int'(a);
  endfunction

  task automatic model_step(int i);
    logic                e_ack;
    type_scr1_mem_resp_e e_resp;
    bit                  due;
    logic [31:0]         lbase;
    longint              a;
    bit                  err;
    if (rst) begin
      p_v[i] = 1'b0;
      chk($sformatf("rst_ack%0d", i), ack[i], 1'b0);
      chk($sformatf("rst_resp%0d", i), resp[i], SCR1_MEM_RESP_NOTRDY);
      chk($sformatf("rst_rdata%0d", i), rdata[i], '0);
      return;
    end
    due = p_v[i] && (p_cyc[i] == cyc);
    if (due) begin
      e_ack  = 1'b1;
      e_resp = p_err[i] ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
    end else if (p_v[i]) begin
      e_ack  = 1'b0;
      e_resp = SCR1_MEM_RESP_NOTRDY;
    end else begin
      e_ack  = 1'b1;
      e_resp = SCR1_MEM_RESP_NOTRDY;
    end
    chk($sformatf("ack%0d@%0d", i, cyc), ack[i], e_ack);
    chk($sformatf("resp%0d@%0d", i, cyc), resp[i], e_resp);
    if (due && !p_wr[i] && !p_err[i]) begin
      lbase = p_addr[i] & ~32'hF;
      for (int b = 0; b < 16; b++) begin
        if (mm.exists(key(i, lbase + b)))
          chk($sformatf("rdata%0d_b%0d@%0d", i, b, cyc), rdata[i][b*8 +: 8], mm[key(i, lbase + b)]);
      end
    end else begin
      chk($sformatf("rdata%0d_zero@%0d", i, cyc), rdata[i], '0);
    end
    if (due) begin
      if (p_wr[i] && !p_err[i])
        for (int k = 0; k < p_nb[i]; k++) mm[key(i, p_addr[i] + k)] = p_wd[i][k*8 +: 8];
      p_v[i] = 1'b0;
    end
    if (e_ack && req[i]) begin
      a   = longint'(addr[i]);
      err = (a >= MEMB);
      case (width[i])
        SCR1_MEM_WIDTH_BYTE:  p_nb[i] = 1;
        SCR1_MEM_WIDTH_HWORD: begin p_nb[i] = 2; if (a % 2 != 0) err = 1; end
        SCR1_MEM_WIDTH_WORD:  begin p_nb[i] = 4; if (a % 4 != 0) err = 1; end
        default:              begin p_nb[i] = 0; err = 1; end
      endcase
      p_v[i]    = 1'b1;
      p_cyc[i]  = cyc + LAT[i];
      p_wr[i]   = (cmd[i] == SCR1_MEM_CMD_WR);
      p_err[i]  = err;
      p_addr[i] = addr[i];
      p_wd[i]   = wdata[i][31:0];
    end
  endtask

  always @(negedge clk) begin : compare
    log_t e;
    for (int i = 0; i < NI; i++) begin
      model_step(i);
      if (resp[i] != SCR1_MEM_RESP_NOTRDY) begin
        e.inst = i; e.cyc = cyc; e.resp = resp[i]; e.data = rdata[i];
        lg.push_back(e);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(int i, type_scr1_mem_cmd_e c, type_scr1_mem_width_e w,
                       logic [31:0] a, logic [31:0] d, output int acc);
    bit got = 0;
    acc = -1;
    req[i] = 1'b1; cmd[i] = c; width[i] = w; addr[i] = a;
    wdata[i] = {96'hC3C3_C3C3_C3C3_C3C3_C3C3_C3C3, d};
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (ack[i]) begin got = 1; acc = cyc; end
      @(posedge clk); #2;
    end
    req[i] = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL accept_timeout inst%0d actual=no_accept required=accept", i);
    end
  endtask

  task automatic expect_next(string nm, int i, int acc, type_scr1_mem_resp_e er,
                             logic [127:0] m, logic [127:0] ed);
    log_t e;
    int n = 0;
    while (lg.size() == 0 && n < 30) begin @(negedge clk); #1; n++; end
    if (lg.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_response required=response", nm);
    end else begin
      e = lg.pop_front();
      chk({nm, "_inst"}, e.inst, i);
      chk({nm, "_cyc"}, e.cyc, acc + LAT[i]);
      chk({nm, "_resp"}, e.resp, er);
      if (m != '0) chk({nm, "_data"}, e.data & m, ed & m);
    end
    @(posedge clk); #2;
  endtask

  localparam logic [127:0] M32 = 128'hFFFF_FFFF;
  localparam logic [127:0] M64 = 128'hFFFF_FFFF_FFFF_FFFF;

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int a0, a1, a2, a3;
    for (int i = 0; i < NI; i++) begin
      req[i] = 1'b0; cmd[i] = SCR1_MEM_CMD_RD; width[i] = SCR1_MEM_WIDTH_WORD;
      addr[i] = '0; wdata[i] = '0; p_v[i] = 1'b0;
    end
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("reset_ack%0d", i), ack[i], 1'b0);
      chk($sformatf("reset_resp%0d", i), resp[i], SCR1_MEM_RESP_NOTRDY);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;

    // basic word write / read, latency 1
    issue(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h10, 32'hDEADBEEF, a0);
    expect_next("wr10", 0, a0, SCR1_MEM_RESP_RDY_OK, '0, '0);
    issue(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h14, 32'h01020304, a0);
    expect_next("wr14", 0, a0, SCR1_MEM_RESP_RDY_OK, '0, '0);
    issue(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0, a0);
    expect_next("rd10", 0, a0, SCR1_MEM_RESP_RDY_OK, M64, 128'h01020304_DEADBEEF);

    // byte lane placement
    issue(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h20, 32'h11223344, a0);
    expect_next("wr20", 0, a0, SCR1_MEM_RESP_RDY_OK, '0, '0);
    issue(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h24, 32'h55667788, a0);
    expect_next("wr24", 0, a0, SCR1_MEM_RESP_RDY_OK, '0, '0);
    issue(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h23, 32'hFFFFFFA5, a0);
    expect_next("wrb23", 0, a0, SCR1_MEM_RESP_RDY_OK, '0, '0);
    issue(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h20, 32'h0, a0);
    expect_next("rd20", 0, a0, SCR1_MEM_RESP_RDY_OK, M64, 128'h55667788_A5223344);

    // latency 3, errors and boundaries
    issue(1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h0, 32'hCAFEF00D, a0);
    expect_next("l3_wr0", 1, a0, SCR1_MEM_RESP_RDY_OK, '0, '0);
    issue(1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h1, 32'h00001234, a0);
    @(negedge clk);
    chk("busy_ack_n1", ack[1], 1'b0);
    @(posedge clk); #2;
    @(negedge clk);
    chk("busy_ack_n2", ack[1], 1'b0);
    expect_next("hw_misalign", 1, a0, SCR1_MEM_RESP_RDY_ER, '0, '0);
    issue(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0, a0);
    expect_next("rd0_unchanged", 1, a0, SCR1_MEM_RESP_RDY_OK, M32, 128'hCAFEF00D);
    issue(1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, 32'h2, 32'h0000BEEF, a0);
    expect_next("hw_wr2", 1, a0, SCR1_MEM_RESP_RDY_OK, '0, '0);
    issue(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0, a0);
    expect_next("rd0_hw", 1, a0, SCR1_MEM_RESP_RDY_OK, M32, 128'hBEEFF00D);
    issue(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h4000, 32'h0, a0);
    expect_next("rd_oor", 1, a0, SCR1_MEM_RESP_RDY_ER, ~128'h0, 128'h0);
    issue(1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h3FFC, 32'h0BADC0DE, a0);
    expect_next("wr_last", 1, a0, SCR1_MEM_RESP_RDY_OK, '0, '0);
    issue(1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h3FF0, 32'h0, a0);
    expect_next("rd_last", 1, a0, SCR1_MEM_RESP_RDY_OK, M32 << 96, 128'h0BADC0DE << 96);

    // back-to-back, latency 1
    issue(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0A0B0C0D, a0);
    issue(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0, a1);
    issue(0, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h77778888, a2);
    issue(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0, a3);
    chk("b2b_acc1", a1, a0 + 1);
    chk("b2b_acc2", a2, a0 + 2);
    chk("b2b_acc3", a3, a0 + 3);
    expect_next("b2b_wr0", 0, a0, SCR1_MEM_RESP_RDY_OK, '0, '0);
    expect_next("b2b_rd0", 0, a1, SCR1_MEM_RESP_RDY_OK, M32, 128'h0A0B0C0D);
    expect_next("b2b_wr10", 0, a2, SCR1_MEM_RESP_RDY_OK, '0, '0);
    expect_next("b2b_rd10", 0, a3, SCR1_MEM_RESP_RDY_OK, M64, 128'h01020304_77778888);

    // reset during a pending write, latency 4
    issue(2, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h40, 32'hAAAA5555, a0);
    expect_next("l4_wr40", 2, a0, SCR1_MEM_RESP_RDY_OK, '0, '0);
    issue(2, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h40, 32'h12345678, a0);
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ack", ack[2], 1'b0);
    chk("midrst_resp", resp[2], SCR1_MEM_RESP_NOTRDY);
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    chk("midrst_dropped", lg.size(), 0);
    issue(2, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h40, 32'h0, a0);
    expect_next("rd40_old", 2, a0, SCR1_MEM_RESP_RDY_OK, M32, 128'hAAAA5555);

    // width ERROR, then idle
    issue(0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_ERROR, 32'h0, 32'h0, a0);
    expect_next("width_err", 0, a0, SCR1_MEM_RESP_RDY_ER, ~128'h0, 128'h0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_ack", ack[0], 1'b1);
      chk("idle_resp", resp[0], SCR1_MEM_RESP_NOTRDY);
      chk("idle_rdata", rdata[0], '0);
    end
    chk("no_stray_resp", lg.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
